// File: rtl/sfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_pkg
// Purpose  : Shared constants and helpers for the parametrised sync FIFO.
// Revision : 1.0  initial release
// ============================================================================
package sfifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int SFIFO_STD  = 0;
  localparam int SFIFO_FWFT = 1;

  // Defaults reproduce the previous 8-bit x 64 FIFO
  localparam int SFIFO_DATA_W = 8;
  localparam int SFIFO_ADDR_W = 6;

  // Ceiling log2; clog2(1) == 0
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfifo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_param_if
// Purpose  : Producer/consumer bus of the parametrised sync FIFO.
//            slave  = FIFO side, master = user side.
// Revision : 1.0  initial release
// ============================================================================
interface sfifo_param_if
  import sfifo_pkg::*;
#(
  parameter int DATA_W = SFIFO_DATA_W,
  parameter int ADDR_W = SFIFO_ADDR_W
);

  logic              w_en;
  logic [DATA_W-1:0] din;
  logic              r_en;
  logic              err_clr;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  w_en, din, r_en, err_clr,
    output dout, dout_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport master (
    output w_en, din, r_en, err_clr,
    input  dout, dout_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/sfifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_mem
// Purpose  : DEPTH x DATA_W register array, synchronous write port and
//            asynchronous read port. Contents are deliberately not reset.
// Revision : 1.0  initial release
// ============================================================================
module sfifo_mem
  import sfifo_pkg::*;
#(
  parameter int DATA_W = SFIFO_DATA_W,
  parameter int DEPTH  = (1 << SFIFO_ADDR_W),
  localparam int AW    = clog2(DEPTH)
) (
  input  wire               clk,
  input  wire               we,
  input  wire  [AW-1:0]     waddr,
  input  wire  [DATA_W-1:0] wdata,
  input  wire  [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store one word per accepted write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: combinational lookup so FWFT can present the head word
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/sfifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_param
// Purpose  : Parametrised single-clock FIFO with exact occupancy count,
//            almost-full/almost-empty thresholds, standard or FWFT read
//            mode, and sticky overflow/underflow flags with clear.
// Revision : 1.0  initial release
// ============================================================================
module sfifo_param
  import sfifo_pkg::*;
#(
  parameter int DATA_W   = SFIFO_DATA_W,
  parameter int ADDR_W   = SFIFO_ADDR_W,
  parameter int FWFT     = SFIFO_STD,
  parameter int AF_LEVEL = (1 << ADDR_W) - 2,
  parameter int AE_LEVEL = 2
) (
  input wire           clk,
  input wire           rst,
  sfifo_param_if.slave bus
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  // Thresholds must leave a usable window between the two almost flags
  if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("sfifo_param: need 0 < AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  if (!((FWFT == SFIFO_STD) || (FWFT == SFIFO_FWFT))) begin : g_bad_mode
    $error("sfifo_param: FWFT must be SFIFO_STD or SFIFO_FWFT");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rdata;

  // Status flags decode only from the registered count (no w_en/r_en path)
  always_comb begin
    full  = (count_q == DEPTH_CNT);
    empty = (count_q == '0);
  end

  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Accept decisions, pointer/count advance and sticky error update
  always_comb begin
    wr_acc      = bus.w_en & ~full;
    rd_acc      = bus.r_en & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    // Pointers are exactly ADDR_W wide, so increment wraps DEPTH-1 -> 0
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A fresh error in the clearing cycle keeps the flag set
    overflow_d  = (bus.w_en & full)  | (overflow_q  & ~bus.err_clr);
    underflow_d = (bus.r_en & empty) | (underflow_q & ~bus.err_clr);
  end

  // Control state registers; async active-low reset empties the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sfifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.din),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  if (FWFT == SFIFO_FWFT) begin : g_fwft
    // Head word shown directly; forced to zero while empty so the output
    // is defined (and zero) after reset instead of exposing stale memory
    always_comb begin
      bus.dout       = empty ? '0 : rdata;
      bus.dout_valid = ~empty;
    end
  end else begin : g_std
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;

    // Capture the popped word on the accepting edge; hold otherwise
    always_comb begin
      dout_d       = rd_acc ? rdata : dout_q;
      dout_valid_d = rd_acc;
    end

    // Registered read data and its one-cycle valid pulse
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_q       <= dout_d;
        dout_valid_q <= dout_valid_d;
      end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sfifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfifo_param
// Purpose  : Self-checking bench for sfifo_param, standard and FWFT
//            instances driven with identical stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_sfifo_param;
  import sfifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          w_en    = 1'b0;
  logic          r_en    = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] din     = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sfifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_std ();
  sfifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_fw ();

  assign bus_std.w_en    = w_en;
  assign bus_std.din     = din;
  assign bus_std.r_en    = r_en;
  assign bus_std.err_clr = err_clr;
  assign bus_fw.w_en     = w_en;
  assign bus_fw.din      = din;
  assign bus_fw.r_en     = r_en;
  assign bus_fw.err_clr  = err_clr;

  sfifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(SFIFO_STD),
                .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
    .clk (clk), .rst (rst), .bus (bus_std.slave));

  sfifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(SFIFO_FWFT),
                .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fw (
    .clk (clk), .rst (rst), .bus (bus_fw.slave));

  // ---------------- reference model (queue based) ----------------
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_udf;

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic model_step();
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_ovf   = (w_en && was_full)  || (m_ovf && !err_clr);
    m_udf   = (r_en && was_empty) || (m_udf && !err_clr);
    m_valid = 1'b0;
    if (r_en && !was_empty) begin
      m_dout  = q.pop_front();
      m_valid = 1'b1;
    end
    if (w_en && !was_full) q.push_back(din);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int n;
    logic [DW-1:0] head;
    n    = q.size();
    head = (n > 0) ? q[0] : '0;
    check("std.count",  32'(bus_std.count),     32'(n));
    check("std.full",   32'(bus_std.full),      32'(n == DEPTH));
    check("std.empty",  32'(bus_std.empty),     32'(n == 0));
    check("std.af",     32'(bus_std.almost_full),  32'(n >= AF));
    check("std.ae",     32'(bus_std.almost_empty), 32'(n <= AE));
    check("std.ovf",    32'(bus_std.overflow),  32'(m_ovf));
    check("std.udf",    32'(bus_std.underflow), 32'(m_udf));
    check("std.dout",   32'(bus_std.dout),      32'(m_dout));
    check("std.valid",  32'(bus_std.dout_valid), 32'(m_valid));
    check("fw.count",   32'(bus_fw.count),      32'(n));
    check("fw.full",    32'(bus_fw.full),       32'(n == DEPTH));
    check("fw.empty",   32'(bus_fw.empty),      32'(n == 0));
    check("fw.ovf",     32'(bus_fw.overflow),   32'(m_ovf));
    check("fw.udf",     32'(bus_fw.underflow),  32'(m_udf));
    check("fw.dout",    32'(bus_fw.dout),       32'(head));
    check("fw.valid",   32'(bus_fw.dout_valid), 32'(n > 0));
  endtask

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    w_en    = w;
    din     = d;
    r_en    = r;
    err_clr = c;
  endtask

  // One clock: model takes the pre-edge inputs, DUTs sampled 1 ns after
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic [AW:0]   e_count;
    logic          e_full;
    logic          e_empty;
    logic          e_af;
    logic          e_ae;
    logic [DW-1:0] e_dout;
    logic          e_valid;
  } vec_t;

  vec_t vt[17];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    model_reset();
    drive(0, '0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst.std.empty", 32'(bus_std.empty), 32'd1);
    check("rst.std.ae",    32'(bus_std.almost_empty), 32'd1);
    rst = 1'b1;

    // Fill 0x10..0x17 then drain; expectations taken from the test plan
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{w: 1'b1, d: DW'(8'h10 + i), r: 1'b0,
                e_count: (AW+1)'(i + 1), e_full: (i == 7), e_empty: 1'b0,
                e_af: (i >= 5), e_ae: (i < 2), e_dout: 8'h00, e_valid: 1'b0};
    end
    for (int i = 0; i < 8; i++) begin
      vt[8+i] = '{w: 1'b0, d: 8'h00, r: 1'b1,
                  e_count: (AW+1)'(7 - i), e_full: 1'b0, e_empty: (i == 7),
                  e_af: ((7 - i) >= 6), e_ae: ((7 - i) <= 2),
                  e_dout: DW'(8'h10 + i), e_valid: 1'b1};
    end
    vt[16] = '{w: 1'b0, d: 8'h00, r: 1'b0, e_count: '0, e_full: 1'b0,
               e_empty: 1'b1, e_af: 1'b0, e_ae: 1'b1, e_dout: 8'h17, e_valid: 1'b0};

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].w, vt[i].d, vt[i].r, 1'b0);
      cycle();
      check("tbl.count", 32'(bus_std.count),        32'(vt[i].e_count));
      check("tbl.full",  32'(bus_std.full),         32'(vt[i].e_full));
      check("tbl.empty", 32'(bus_std.empty),        32'(vt[i].e_empty));
      check("tbl.af",    32'(bus_std.almost_full),  32'(vt[i].e_af));
      check("tbl.ae",    32'(bus_std.almost_empty), 32'(vt[i].e_ae));
      check("tbl.dout",  32'(bus_std.dout),         32'(vt[i].e_dout));
      check("tbl.valid", 32'(bus_std.dout_valid),   32'(vt[i].e_valid));
    end

    // Overflow on a full FIFO: rejected word never appears
    for (int i = 0; i < 8; i++) begin drive(1, DW'(8'h20 + i), 0, 0); cycle(); end
    drive(1, 8'hAA, 0, 0); cycle();
    check("ovf.set",   32'(bus_std.overflow), 32'd1);
    check("ovf.count", 32'(bus_std.count),    32'd8);
    drive(0, '0, 0, 0); cycle();
    check("ovf.sticky", 32'(bus_std.overflow), 32'd1);
    drive(0, '0, 0, 1); cycle();
    check("ovf.clr", 32'(bus_std.overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, 1, 0); cycle();
      check("ovf.data", 32'(bus_std.dout), 32'(8'h20 + i));
    end

    // Underflow on empty; clear and new error together keeps it set
    drive(0, '0, 1, 0); cycle();
    check("udf.set",   32'(bus_std.underflow),  32'd1);
    check("udf.dout",  32'(bus_std.dout),       32'h27);
    check("udf.valid", 32'(bus_std.dout_valid), 32'd0);
    check("udf.count", 32'(bus_std.count),      32'd0);
    drive(0, '0, 1, 1); cycle();
    check("udf.setwins", 32'(bus_std.underflow), 32'd1);
    drive(0, '0, 0, 1); cycle();
    check("udf.clr", 32'(bus_std.underflow), 32'd0);

    // Simultaneous push/pop at count 4 for 20 cycles
    for (int i = 0; i < 4; i++) begin drive(1, DW'(8'h40 + i), 0, 0); cycle(); end
    for (int i = 0; i < 20; i++) begin
      drive(1, DW'(8'h44 + i), 1, 0); cycle();
      check("sim.count", 32'(bus_std.count), 32'd4);
      check("sim.dout",  32'(bus_std.dout),  32'(8'h40 + i));
    end
    for (int i = 0; i < 4; i++) begin drive(0, '0, 1, 0); cycle(); end

    // Full with both requests: read wins, write rejected
    for (int i = 0; i < 8; i++) begin drive(1, DW'(8'h60 + i), 0, 0); cycle(); end
    drive(1, 8'hBB, 1, 0); cycle();
    check("bnd.full.count", 32'(bus_std.count),    32'd7);
    check("bnd.full.ovf",   32'(bus_std.overflow), 32'd1);
    check("bnd.full.dout",  32'(bus_std.dout),     32'h60);
    for (int i = 0; i < 7; i++) begin drive(0, '0, 1, 1); cycle(); end
    // Empty with both requests: write wins, read rejected
    drive(1, 8'hCC, 1, 0); cycle();
    check("bnd.empty.count", 32'(bus_std.count),     32'd1);
    check("bnd.empty.udf",   32'(bus_std.underflow), 32'd1);
    check("bnd.empty.valid", 32'(bus_std.dout_valid), 32'd0);
    check("bnd.empty.fwd",   32'(bus_fw.dout),       32'hCC);
    drive(0, '0, 1, 1); cycle();

    // FWFT display, then async reset mid-stream
    drive(1, 8'h5A, 0, 0); cycle();
    check("fw.show",  32'(bus_fw.dout),       32'h5A);
    check("fw.valid", 32'(bus_fw.dout_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin drive(1, DW'(8'h5B + i), 0, 0); cycle(); end
    drive(0, '0, 0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    check("arst.fw.count", 32'(bus_fw.count),       32'd0);
    check("arst.fw.empty", 32'(bus_fw.empty),       32'd1);
    check("arst.fw.valid", 32'(bus_fw.dout_valid),  32'd0);
    check("arst.std.count", 32'(bus_std.count),     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1, 8'h66, 0, 0); cycle();
    check("arst.fw.first", 32'(bus_fw.dout),       32'h66);
    check("arst.fw.fv",    32'(bus_fw.dout_valid), 32'd1);

    // Randomised traffic in write-heavy then read-heavy phases
    for (int i = 0; i < 400; i++) begin
      int wp;
      int rp;
      wp = ((i / 50) % 2 == 0) ? 75 : 30;
      rp = 100 - wp;
      drive(($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < rp),
            ($urandom_range(0, 99) < 5));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sfifo_param.md
Name: sfifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit x 64 sync FIFO.
- Generalised data width and power-of-two depth.
- Adds:
  - exact occupancy count
  - almost-full / almost-empty thresholds
  - selectable standard or first-word-fall-through (FWFT) read mode
  - sticky overflow/underflow error flags with software clear
- Sits between producer/consumer blocks in the same clock domain; no flop-in stage, so flags are exact with zero skid.

Parameters:
- DATA_W, 8: data width in bits.
- ADDR_W, 6: pointer width; DEPTH = 2**ADDR_W entries (default 64).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2: almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserted when count <= AE_LEVEL.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  reset, asynchronous, active-low.
- w_en  input  1  write request.
- din  input  DATA_W  write data.
- r_en  input  1  read request (pop).
- dout  output  DATA_W  read data.
- dout_valid  output  1  dout holds valid data.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.
- err_clr  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst low, async):
  - wr_ptr = rd_ptr = 0, count = 0
  - dout = 0, dout_valid = 0
  - overflow = underflow = 0
  - Flags follow from count = 0: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents; the first write after deassertion lands at address 0.
- Flags and count are decoded from registered count only; there is no combinational path from w_en/r_en.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = w_en & ~full
  - rd_acc = r_en & ~empty
  - No write-through: a write into a full FIFO is rejected even with a simultaneous read.
  - A read on an empty FIFO is rejected even with a simultaneous write.
- Write accepted: mem[wr_ptr] <= din; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Read accepted: rd_ptr increments with the same wrap.
- Count update:
  - +1 for wr_acc only
  - -1 for rd_acc only
  - unchanged when both or neither are accepted
- Error flags:
  - w_en & full sets overflow; r_en & empty sets underflow.
  - Both are sticky until err_clr.
  - If err_clr and a new error occur in the same cycle, set wins.
  - Rejected operations change no pointer, count or data.
- FWFT = 0 (standard mode):
  - On rd_acc, dout <= mem[rd_ptr] at the same edge, so data is valid 1 cycle after the r_en cycle.
  - dout_valid is a 1-cycle pulse registered from rd_acc.
  - dout holds its last value otherwise.
- FWFT = 1:
  - dout = mem[rd_ptr] combinationally; dout_valid = ~empty.
  - r_en acknowledges the displayed word.
  - A write into an empty FIFO appears on dout the cycle after the write edge.
- Thresholds: AF_LEVEL and AE_LEVEL must satisfy 0 < AE_LEVEL < AF_LEVEL <= DEPTH. Violations are an elaboration error via a generate-time check.

Decomposition:
- Shared header/package sfifo_pkg:
  - mode constants SFIFO_STD = 0 and SFIFO_FWFT = 1
  - default DATA_W/ADDR_W
  - clog2 helper function
- One sub-module, sfifo_mem: DEPTH x DATA_W register array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata), with no reset.
- The top holds pointers, count, flags, error logic and the mode-dependent output stage.

Test Plan:
All scenarios use DATA_W = 8, ADDR_W = 3 (DEPTH = 8), AF_LEVEL = 6, AE_LEVEL = 2.
- Fill/drain, FWFT = 0:
  - Write 0x10..0x17 on 8 consecutive cycles -> count 1..8; almost_empty drops at count 3; almost_full rises at count 6; full at count 8.
  - Read 8 -> dout 0x10..0x17, each 1 cycle after r_en with a dout_valid pulse; empty = 1 at the end.
- Overflow, full FIFO: w_en with din = 0xAA -> overflow = 1 next cycle and stays high; count stays 8; a later read returns the original data, with no 0xAA present. Pulse err_clr -> overflow = 0.
- Underflow on empty FIFO: r_en -> underflow = 1; dout unchanged, no dout_valid, count 0. Assert err_clr and r_en in the same cycle -> underflow remains 1 (set wins).
- Simultaneous ops at count 4: w_en & r_en for 20 cycles with an incrementing pattern -> count stays 4, pointers wrap twice, read data is in exact order.
- Boundaries:
  - Full plus simultaneous w_en & r_en -> read accepted, write rejected, overflow set, count 7.
  - Empty plus both -> write accepted, underflow set, count 1.
- FWFT = 1 and reset: write 0x5A to empty -> next cycle dout = 0x5A, dout_valid = 1 with no r_en. Write 3 more, then drop rst mid-stream -> count 0, empty = 1, dout_valid = 0 immediately (async). Next write lands at address 0 and is the next word displayed.
